// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 encryptor: top-level and swap-sequencer
// state encodings, table/key sizes and key-byte selection.
package rc4_pkg;

    localparam int unsigned S_SIZE    = 256;
    localparam int unsigned KEY_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA_SWAP,
        PRGA_SWAP,
        PRGA_RD_F,
        PRGA_CAP_F,
        PRGA_WR_CT,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        SW_IDLE,
        SW_RD_I,
        SW_CAP_I,
        SW_RD_J,
        SW_CAP_J,
        SW_WR_I,
        SW_WR_J
    } swap_state_t;

    // byte0 is the most significant byte of the 24-bit key
    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
        case (idx)
            2'd0:    return key[23:16];
            2'd1:    return key[15:8];
            default: return key[7:0];
        endcase
    endfunction

    function automatic logic [1:0] next_key_idx(input logic [1:0] idx);
        return (idx == 2'(KEY_BYTES - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rc4_swap_seq.sv
// Read-i / read-j / write-i / write-j swap sequencer shared by KSA and PRGA.
// Emits next-cycle S-port requests so the top can register the memory port.
module rc4_swap_seq
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       abort,
    input  logic       j_clr,
    input  logic [7:0] i_in,
    input  logic [7:0] inc,
    input  logic [7:0] s_q,
    output logic       ready,
    output logic       req_valid,
    output logic       req_wren,
    output logic       req_rden,
    output logic [7:0] req_addr,
    output logic [7:0] req_data,
    output logic [7:0] si,
    output logic [7:0] sj
);

    swap_state_t st, st_next;
    logic [7:0]  i_q, inc_q, j_q;
    logic        accept;

    always_comb begin
        ready   = (st == SW_WR_J);
        accept  = go && !abort && ((st == SW_IDLE) || (st == SW_WR_J));
        st_next = st;
        case (st)
            SW_IDLE:  st_next = accept ? SW_RD_I : SW_IDLE;
            SW_RD_I:  st_next = SW_CAP_I;
            SW_CAP_I: st_next = SW_RD_J;
            SW_RD_J:  st_next = SW_CAP_J;
            SW_CAP_J: st_next = SW_WR_I;
            SW_WR_I:  st_next = SW_WR_J;
            SW_WR_J:  st_next = accept ? SW_RD_I : SW_IDLE;
            default:  st_next = SW_IDLE;
        endcase
        if (abort) begin
            st_next = SW_IDLE;
        end

        // request describes the port operation of the state being entered
        req_valid = (st_next != SW_IDLE);
        req_wren  = 1'b0;
        req_rden  = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        case (st_next)
            SW_RD_I: begin
                req_addr = i_in;
                req_rden = 1'b1;
            end
            SW_RD_J: begin
                req_addr = j_q + s_q + inc_q;
                req_rden = 1'b1;
            end
            SW_WR_I: begin
                req_addr = i_q;
                req_data = s_q;
                req_wren = 1'b1;
            end
            SW_WR_J: begin
                req_addr = j_q;
                req_data = si;
                req_wren = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= SW_IDLE;
            i_q   <= '0;
            inc_q <= '0;
            j_q   <= '0;
            si    <= '0;
            sj    <= '0;
        end else begin
            st <= st_next;
            if (accept) begin
                i_q   <= i_in;
                inc_q <= inc;
            end
            if (j_clr) begin
                j_q <= '0;
            end else if (st == SW_CAP_I) begin
                j_q <= j_q + s_q + inc_q;
            end
            if (st == SW_CAP_I) begin
                si <= s_q;
            end
            if (st == SW_CAP_J) begin
                sj <= s_q;
            end
        end
    end

endmodule

// File: rtl/rc4_encrypt_core.sv
// RC4 encryptor: S init, key schedule and keystream XOR over a plaintext image,
// driving external S, plaintext and ciphertext memories through registered ports.
module rc4_encrypt_core
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int AW      = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [23:0]   secret_key,
    output logic          busy,
    output logic          done,
    output logic [7:0]    s_address,
    output logic [7:0]    s_data,
    output logic          s_wren,
    output logic          s_rden,
    input  logic [7:0]    s_q,
    output logic [AW-1:0] pt_address,
    output logic          pt_rden,
    input  logic [7:0]    pt_q,
    output logic [AW-1:0] ct_address,
    output logic [7:0]    ct_data,
    output logic          ct_wren
);

    localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

    state_t        state, state_next;
    logic [23:0]   key_q, key_d;
    logic [7:0]    i, i_d;
    logic [AW-1:0] k, k_d;
    logic [1:0]    kidx, kidx_d;
    logic          ksa_last, ksa_last_d;

    logic          seq_go, seq_abort, seq_j_clr, seq_ready;
    logic [7:0]    seq_i, seq_inc, seq_si, seq_sj;
    logic          seq_req_valid, seq_req_wren, seq_req_rden;
    logic [7:0]    seq_req_addr, seq_req_data;

    logic [7:0]    t_s_addr, t_s_data;
    logic          t_s_wren, t_s_rden;
    logic [AW-1:0] t_pt_addr, t_ct_addr;
    logic          t_pt_rden, t_ct_wren;
    logic [7:0]    t_ct_data;

    rc4_swap_seq u_swap (
        .clk       (clk),
        .reset     (reset),
        .go        (seq_go),
        .abort     (seq_abort),
        .j_clr     (seq_j_clr),
        .i_in      (seq_i),
        .inc       (seq_inc),
        .s_q       (s_q),
        .ready     (seq_ready),
        .req_valid (seq_req_valid),
        .req_wren  (seq_req_wren),
        .req_rden  (seq_req_rden),
        .req_addr  (seq_req_addr),
        .req_data  (seq_req_data),
        .si        (seq_si),
        .sj        (seq_sj)
    );

    always_comb begin
        state_next = state;
        key_d      = key_q;
        i_d        = i;
        k_d        = k;
        kidx_d     = kidx;
        ksa_last_d = ksa_last;
        seq_go     = 1'b0;
        seq_abort  = 1'b0;
        seq_j_clr  = 1'b0;
        seq_i      = i;
        seq_inc    = '0;
        t_s_addr   = '0;
        t_s_data   = '0;
        t_s_wren   = 1'b0;
        t_s_rden   = 1'b0;
        t_pt_addr  = '0;
        t_pt_rden  = 1'b0;
        t_ct_addr  = '0;
        t_ct_data  = '0;
        t_ct_wren  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = INIT;
                    key_d      = secret_key;
                    i_d        = '0;
                    k_d        = '0;
                    kidx_d     = '0;
                    ksa_last_d = 1'b0;
                    seq_j_clr  = 1'b1;
                    t_s_wren   = 1'b1;
                end
            end
            INIT: begin
                // the final INIT cycle hands the port to the first KSA swap
                if (i == 8'(S_SIZE - 1)) begin
                    seq_go     = 1'b1;
                    seq_i      = '0;
                    seq_inc    = key_byte(key_q, kidx);
                    i_d        = 8'd1;
                    kidx_d     = next_key_idx(kidx);
                    state_next = KSA_SWAP;
                end else begin
                    i_d      = i + 8'd1;
                    t_s_addr = i + 8'd1;
                    t_s_data = i + 8'd1;
                    t_s_wren = 1'b1;
                end
            end
            KSA_SWAP: begin
                if (seq_ready) begin
                    seq_go = 1'b1;
                    if (!ksa_last) begin
                        seq_i      = i;
                        seq_inc    = key_byte(key_q, kidx);
                        i_d        = i + 8'd1;
                        kidx_d     = next_key_idx(kidx);
                        ksa_last_d = (i == 8'(S_SIZE - 1));
                    end else begin
                        seq_i      = 8'd1;
                        seq_j_clr  = 1'b1;
                        i_d        = 8'd1;
                        state_next = PRGA_SWAP;
                    end
                end
            end
            PRGA_SWAP: begin
                if (seq_ready) begin
                    state_next = PRGA_RD_F;
                    t_s_addr   = seq_si + seq_sj;
                    t_s_rden   = 1'b1;
                    t_pt_addr  = k;
                    t_pt_rden  = 1'b1;
                end
            end
            PRGA_RD_F: state_next = PRGA_CAP_F;
            PRGA_CAP_F: begin
                state_next = PRGA_WR_CT;
                t_ct_addr  = k;
                t_ct_data  = s_q ^ pt_q;
                t_ct_wren  = 1'b1;
            end
            PRGA_WR_CT: begin
                if (k == K_LAST) begin
                    state_next = DONE;
                end else begin
                    seq_go     = 1'b1;
                    seq_i      = i + 8'd1;
                    i_d        = i + 8'd1;
                    k_d        = k + 1'b1;
                    state_next = PRGA_SWAP;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (stop && (state != IDLE)) begin
            state_next = IDLE;
            seq_abort  = 1'b1;
            seq_go     = 1'b0;
            seq_j_clr  = 1'b0;
            t_s_addr   = '0;
            t_s_data   = '0;
            t_s_wren   = 1'b0;
            t_s_rden   = 1'b0;
            t_pt_addr  = '0;
            t_pt_rden  = 1'b0;
            t_ct_addr  = '0;
            t_ct_data  = '0;
            t_ct_wren  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            key_q      <= '0;
            i          <= '0;
            k          <= '0;
            kidx       <= '0;
            ksa_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            s_address  <= '0;
            s_data     <= '0;
            s_wren     <= 1'b0;
            s_rden     <= 1'b0;
            pt_address <= '0;
            pt_rden    <= 1'b0;
            ct_address <= '0;
            ct_data    <= '0;
            ct_wren    <= 1'b0;
        end else begin
            state      <= state_next;
            key_q      <= key_d;
            i          <= i_d;
            k          <= k_d;
            kidx       <= kidx_d;
            ksa_last   <= ksa_last_d;
            busy       <= (state_next != IDLE) && (state_next != DONE);
            done       <= (state_next == DONE);
            s_address  <= seq_req_valid ? seq_req_addr : t_s_addr;
            s_data     <= seq_req_valid ? seq_req_data : t_s_data;
            s_wren     <= seq_req_valid ? seq_req_wren : t_s_wren;
            s_rden     <= seq_req_valid ? seq_req_rden : t_s_rden;
            pt_address <= t_pt_addr;
            pt_rden    <= t_pt_rden;
            ct_address <= t_ct_addr;
            ct_data    <= t_ct_data;
            ct_wren    <= t_ct_wren;
        end
    end

endmodule

// File: doc/rc4_encrypt_core.md
# rc4_encrypt_core

Hardware RC4 encryptor that turns a plaintext ROM/RAM image into a ciphertext image under a 24-bit secret key. It is the producer side of the decryption cores. It generates the encrypted-message images that the key-search cores consume, and it gives the bench a round-trip check. It owns the full RC4 sequence (S init, key schedule, keystream XOR) and drives three external single-port memories: S memory, plaintext source and ciphertext sink.

## Interface
Parameters:
- MSG_LEN, 32: message length in bytes, 1..32.
- AW, 5: plaintext/ciphertext address width.

Ports:
- clk, in, 1: single clock, all logic on rising edge.
- reset, in, 1: asynchronous, active-high; forces IDLE.
- start, in, 1: sampled only in IDLE; latches secret_key.
- stop, in, 1: synchronous abort to IDLE, no done.
- secret_key, in, 24: key; byte0 = [23:16], byte1 = [15:8], byte2 = [7:0].
- busy, out, 1: high from the cycle after start until done.
- done, out, 1: one-cycle pulse after the last ciphertext write.
- s_address, out, 8: S-memory address.
- s_data, out, 8: S-memory write data.
- s_wren, out, 1: S-memory write enable.
- s_rden, out, 1: S-memory read enable.
- s_q, in, 8: S-memory read data.
- pt_address, out, AW: plaintext read address.
- pt_rden, out, 1: plaintext read enable.
- pt_q, in, 8: plaintext read data.
- ct_address, out, AW: ciphertext write address.
- ct_data, out, 8: ciphertext byte.
- ct_wren, out, 1: ciphertext write enable.

## Operation
- Memory read latency: an address driven in cycle N returns data on s_q/pt_q during N+1, captured at the end of N+1.
- IDLE: all enables low. When start is high, latch the key, clear i/j/k, go to INIT.
- INIT: one write per cycle, S[i]=i for i=0..255, giving 256 cycles.
- KSA: for i=0..255:
  - j = j + S[i] + key[i mod 3], mod 256.
  - Swap S[i] and S[j].
  - Fixed 6 cycles per iteration: RD_I, CAP_I, RD_J, CAP_J, WR_I (S[i]←Sj), WR_J (S[j]←Si).
- Swap with i==j is legal. Values are captured before the writes, so both writes carry the same value.
- PRGA: reset i=j=0, then for k=0..MSG_LEN-1:
  - i=i+1, j=j+S[i].
  - Swap S[i] and S[j].
  - f = S[(Si+Sj) mod 256].
  - ct[k] = f XOR pt[k].
- PRGA takes 9 cycles per byte: RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, RD_F (pt read in parallel), CAP_F, WR_CT.
- DONE: pulse done for one cycle, drop busy, return to IDLE.
- All index arithmetic is 8-bit and wraps mod 256. k is never greater than MSG_LEN-1.
- start while busy: ignored. A key change mid-run has no effect.
- stop: takes effect at the next edge in any non-IDLE state. State goes to IDLE, enables drop, and done is not pulsed. Memory contents are then unspecified.
- s_wren and s_rden are never high in the same cycle. At most one memory transaction per cycle per port.

## Timing
- Reset values: busy=0, done=0, all enables 0, all addresses and data 0. The FSM is in IDLE.
- Reset mid-operation clears everything asynchronously. No partial write occurs after reset asserts.
- Start is sampled at edge E0.
- Cycle counts from E0:
  - INIT write 0 occurs in the cycle after E0.
  - KSA begins at E0+257.
  - PRGA begins at E0+1793.
  - done is high in the cycle at E0 + 1793 + 9·MSG_LEN. For MSG_LEN=32 that is 2081.
- Outputs are registered, with no combinational path from input to output.

## Structure
- Package rc4_pkg holds:
  - The state enum: IDLE, INIT, KSA_*, PRGA_*, DONE.
  - S_SIZE=256 and KEY_BYTES=3.
  - A key-byte select function.
- One sub-module, rc4_swap_seq: the read-i/read-j/write-i/write-j sequencer.
  - Shared by KSA and PRGA.
  - Inputs: i, j-increment source, go.
  - Returns Si, Sj and the new j, with a ready pulse.
- The top FSM owns INIT, the keystream read and the ciphertext write.

## Test plan
- Known vector: key 0x4B6579, pt "Plaintext", MSG_LEN=9. Required ct = BB F3 16 E8 D9 40 AF 0A D3, and done at E0+1874.
- Round trip: load the above ct as pt with the same key. Ct must read back as ASCII "Plaintext" (50 6C 61 69 6E 74 65 78 74).
- INIT check: monitor the S port during INIT. There must be exactly 256 writes with s_data==s_address==0..255 in order, and s_rden must stay low.
- Start while busy: pulse start at E0+500 with a different key. Output must equal the first key's result, with a single done.
- Reset at E0+1000 (mid-KSA):
  - Same cycle: busy=0, all enables 0.
  - A new start then yields the correct known vector.
- Stop at the third PRGA byte:
  - Only ct[0..1] are written, with no done.
  - FSM is back in IDLE, and a new start completes normally.
